// File: rtl/vga_sync_decoder_if.sv
// Sync-input and recovered-timing bundle for vga_sync_decoder.
// master drives the sync pins, slave is the decoder.
interface vga_sync_decoder_if;
  logic       en;
  logic       hsync;
  logic       vsync;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic       active;
  logic       locked;
  logic       err;

  modport master (
    output en, hsync, vsync,
    input  h_count, v_count, h_total, v_total,
    input  active, locked, err
  );

  modport slave (
    input  en, hsync, vsync,
    output h_count, v_count, h_total, v_total,
    output active, locked, err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: counts pixels/lines from incoming
// syncs, measures line/frame length and locks onto the configured mode.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic               clk,
  input logic               arst_n,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_e;

  state_e     state_q, state_d;
  logic       hs_q, vs_q;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [9:0] ht_q, ht_d;
  logic [9:0] vt_q, vt_d;
  logic       h_seen_q, h_seen_d;
  logic [3:0] good_q, good_d;
  logic       err_q, err_d;

  logic        hs_edge, vs_edge;
  logic [10:0] hc_inc, vc_inc;
  logic [9:0]  hc_sat, vc_sat;
  logic        line_mm, frame_mm, mm;
  logic        h_in, v_in;

  assign hs_edge = bus.en & (bus.hsync == SYNC_POL)
                 & (hs_q != SYNC_POL);
  assign vs_edge = bus.en & (bus.vsync == SYNC_POL)
                 & (vs_q != SYNC_POL);

  assign hc_inc = {1'b0, hc_q} + 11'd1;
  assign vc_inc = {1'b0, vc_q} + 11'd1;
  assign hc_sat = hc_inc[10] ? 10'h3ff : hc_inc[9:0];
  assign vc_sat = vc_inc[10] ? 10'h3ff : vc_inc[9:0];

  // Saturation is flagged on the 1022->1023 step so it fires only once.
  assign line_mm = (hs_edge & h_seen_q & (hc_inc != 11'(H_TOTAL)))
                 | (bus.en & ~hs_edge & (hc_q == 10'd1022));
  assign frame_mm = vs_edge & (vc_inc != 11'(V_TOTAL));
  assign mm = line_mm | frame_mm;

  always_comb begin
    hc_d     = hc_q;
    vc_d     = vc_q;
    ht_d     = ht_q;
    vt_d     = vt_q;
    h_seen_d = h_seen_q;
    good_d   = good_q;
    state_d  = state_q;
    err_d    = 1'b0;

    if (hs_edge) begin
      hc_d     = '0;
      ht_d     = hc_sat;
      h_seen_d = 1'b1;
    end else if (bus.en) begin
      hc_d = hc_sat;
    end

    if (vs_edge) begin
      vc_d = '0;
      vt_d = vc_sat;
    end else if (hs_edge) begin
      vc_d = vc_sat;
    end

    unique case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (mm) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (vs_edge) begin
          good_d = good_q + 4'd1;
          if (good_q + 4'd1 == 4'(LOCK_FRAMES))
            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mm) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= SEARCH;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      hc_q     <= '0;
      vc_q     <= '0;
      ht_q     <= '0;
      vt_q     <= '0;
      h_seen_q <= 1'b0;
      good_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (bus.en) begin
        hs_q <= bus.hsync;
        vs_q <= bus.vsync;
      end
      state_q  <= state_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      ht_q     <= ht_d;
      vt_q     <= vt_d;
      h_seen_q <= h_seen_d;
      good_q   <= good_d;
      err_q    <= err_d;
    end
  end

  assign h_in = ({1'b0, hc_q} >= 11'(H_START))
              & ({1'b0, hc_q} < 11'(H_START + H_ACTIVE));
  assign v_in = ({1'b0, vc_q} >= 11'(V_START))
              & ({1'b0, vc_q} < 11'(V_START + V_ACTIVE));

  assign bus.h_count = hc_q;
  assign bus.v_count = vc_q;
  assign bus.h_total = ht_q;
  assign bus.v_total = vt_q;
  assign bus.locked  = (state_q == LOCKED);
  assign bus.active  = bus.locked & h_in & v_in;
  assign bus.err     = err_q;

endmodule
